// File: rtl/adc_pkg.sv
// Shared ADC constants and FSM state encoding for the SPI reader.
// The tuner datapath imports this package for the sample width.
package adc_pkg;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_BITS  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        QUIET = 3'd4
    } adc_state_e;

endpackage

// File: rtl/adc_spi_reader_if.sv
// Start/serial/sample bundle between the ADC SPI reader and its neighbours.
interface adc_spi_reader_if
    import adc_pkg::*;
#(
    parameter int unsigned DATA_BITS = ADC_DATA_BITS
);

    logic                 start;
    logic                 sdata;
    logic                 cs_n;
    logic                 sclk;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 busy;

    modport master (
        input  start, sdata,
        output cs_n, sclk, sample, sample_valid, busy
    );

    modport slave (
        output start, sdata,
        input  cs_n, sclk, sample, sample_valid, busy
    );

endinterface

// File: rtl/adc_sclk_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks while enabled.
module adc_sclk_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));

    // Held at zero while disabled so every frame starts on a full half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!en || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for an AD7476-style ADC: one start pulse runs one frame and
// returns the low DATA_BITS of the shifted word with a one-cycle valid strobe.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = ADC_FRAME_BITS,
    parameter int unsigned DATA_BITS  = ADC_DATA_BITS,
    parameter int unsigned QUIET_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst,
    adc_spi_reader_if.master  bus
);

    localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int unsigned QUIET_W = $clog2(QUIET_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_SETUP = 3'(SETUP);
    localparam logic [2:0] S_SHIFT = 3'(SHIFT);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam logic [2:0] S_QUIET = 3'(QUIET);

    logic [2:0]            state_q,     state_d;
    logic                  cs_n_q,      cs_n_d;
    logic                  sclk_q,      sclk_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [QUIET_W-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic [DATA_BITS-1:0]  sample_q,    sample_d;
    logic                  valid_q,     valid_d;
    logic                  busy_q,      busy_d;

    logic tick_en;
    logic tick;

    assign tick_en = !cs_n_q;

    adc_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_en),
        .tick_c (tick)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic; sclk only moves on divider ticks.
    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (bus.start) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = '0;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else begin
                        // Capture on the rising edge; data was launched on the previous fall.
                        sclk_d    = 1'b1;
                        shift_d   = {shift_q[FRAME_BITS-2:0], bus.sdata};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (tick) begin
                    cs_n_d      = 1'b1;
                    sample_d    = shift_q[DATA_BITS-1:0];
                    valid_d     = 1'b1;
                    quiet_cnt_d = '0;
                    state_d     = S_QUIET;
                end
            end
            S_QUIET: begin
                if (quiet_cnt_q == QUIET_W'(QUIET_CYC - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QUIET_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.sclk         = sclk_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;

endmodule
